// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: default geometry and
// the loader state encoding.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_DEPTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        , ST_CHECK = 3'd3
`endif
    } state_t;

    // States in which the stream handshake is open.
    function automatic logic accepts_beats(input state_t s);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return (s == ST_LOAD) || (s == ST_CHECK);
`else
        return (s == ST_LOAD);
`endif
    endfunction

    // States reported as busy (a load is in flight).
    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_DRAIN)
`ifdef IMEM_LOADER_CHECKSUM_EN
            || (s == ST_CHECK)
`endif
            ;
    endfunction

endpackage

// File: rtl/imem_loader_checksum.sv
// -----------------------------------------------------------------------------
// loader_checksum
// Running mod-2^n sum of the image words, compared against the trailing
// checksum beat. Instantiated by imem_loader only when IMEM_LOADER_CHECKSUM_EN
// is defined.
// Ports:
//   clk, areset   clock, asynchronous active-low reset
//   clear         zero the accumulator (start of a load)
//   accumulate    add data into the accumulator this cycle
//   data          image word, or the checksum beat while comparing
//   match         combinational: accumulator equals data
// -----------------------------------------------------------------------------
module loader_checksum #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         clear,
    input  logic         accumulate,
    input  logic [n-1:0] data,
    output logic         match
);

    logic [n-1:0] sum;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (accumulate) begin
            sum <= sum + data;  // wraps naturally: mod 2^n
        end
    end

    assign match = (sum == data);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Streams 32-bit instruction words into the instruction memory write port and
// holds the RV32 core in reset until a complete image has been written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds CHECK state that
// verifies a trailing mod-2^n checksum beat).
// Ports:
//   clk, areset          clock, asynchronous active-low reset
//   start                pulse: begin a (re)load from IDLE, RUN or ERROR
//   in_valid/in_data/in_last/in_ready   stream handshake
//   imem_we/imem_addr/imem_wd           registered memory write port
//   core_areset          active-low core reset, high only in RUN
//   busy/done/error      status: LOAD|DRAIN|CHECK / RUN / ERROR
//   word_count           image words accepted in the current/last load
// All outputs are registered and derived from the next state.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int n     = DEF_N,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [n-1:0]  in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [n-1:0]  imem_wd,
    output logic          core_areset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   word_count
);

    state_t state, state_next;
    logic   restart;      // start honoured this cycle
    logic   load_accept;  // image beat accepted in LOAD
    logic   beat;

    assign beat = in_valid && in_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic sum_match;

    loader_checksum #(.n(n)) u_checksum (
        .clk        (clk),
        .areset     (areset),
        .clear      (restart),
        .accumulate (load_accept),
        .data       (in_data),
        .match      (sum_match)
    );
`endif

    // NOTE: every signal driven here gets a default first; otherwise a path
    // that skips the assignment infers a latch.
    always_comb begin
        state_next  = state;
        restart     = 1'b0;
        load_accept = 1'b0;
        unique case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LOAD;
                    restart    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    load_accept = 1'b1;
                    if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_DRAIN;
`endif
                    end else if (word_count == (AW+1)'(DEPTH - 1)) begin
                        // Memory full without in_last: this beat is the last
                        // write, so the address never wraps.
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_DRAIN: state_next = ST_RUN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                // in_last is deliberately ignored on the checksum beat.
                if (beat) begin
                    state_next = sum_match ? ST_RUN : ST_ERROR;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wd     <= '0;
            core_areset <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            word_count  <= '0;
        end else begin
            state       <= state_next;
            in_ready    <= accepts_beats(state_next);
            busy        <= is_busy(state_next);
            done        <= (state_next == ST_RUN);
            error       <= (state_next == ST_ERROR);
            core_areset <= (state_next == ST_RUN);
            imem_we     <= load_accept;
            if (load_accept) begin
                imem_addr <= word_count[AW-1:0];
                imem_wd   <= in_data;
            end
            if (restart) begin
                word_count <= '0;
            end else if (load_accept) begin
                word_count <= word_count + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Expected memory writes are queued when
// a beat is handed over and compared when imem_we appears. The checksum
// scenarios are included when IMEM_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int N     = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          areset;
    logic          start;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_last;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [N-1:0]  imem_wd;
    logic          core_areset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    imem_loader #(.n(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .areset      (areset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wd     (imem_wd),
        .core_areset (core_areset),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } wr_t;

    wr_t           exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            we_pulses   = 0;
    logic [AW-1:0] addr_model  = '0;
    logic [N-1:0]  sum_model   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (areset && imem_we) begin
            we_pulses++;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e.addr));
                check("wr_data", 64'(imem_wd), 64'(e.data));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),    64'd0);
        check({tag, "_imem_we"},    64'(imem_we),     64'd0);
        check({tag, "_imem_addr"},  64'(imem_addr),   64'd0);
        check({tag, "_imem_wd"},    64'(imem_wd),     64'd0);
        check({tag, "_core_rst"},   64'(core_areset), 64'd0);
        check({tag, "_busy"},       64'(busy),        64'd0);
        check({tag, "_done"},       64'(done),        64'd0);
        check({tag, "_error"},      64'(error),       64'd0);
        check({tag, "_word_count"}, 64'(word_count),  64'd0);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        addr_model = '0;
        sum_model  = '0;
    endtask

    // Offer one beat; returns #1 after the edge at which it was accepted.
    task automatic send(input logic [N-1:0] d, input logic l, input bit is_image);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("in_ready", 64'(in_ready), 64'd1);
        if (in_ready && is_image) begin
            exp_q.push_back('{addr: addr_model, data: d});
            addr_model++;
            sum_model += d;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the in_last beat; ends with the loader in RUN.
    task automatic complete_image(input int words);
        check("core_rst_at_last", 64'(core_areset), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(sum_model, 1'b1, 1'b0);
`else
        check("busy_drain", 64'(busy), 64'd1);
        @(posedge clk); #1;
`endif
        check("core_rst_run", 64'(core_areset), 64'd1);
        check("done_run", 64'(done), 64'd1);
        check("busy_run", 64'(busy), 64'd0);
        check("word_count", 64'(word_count), 64'(words));
        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset   = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk) areset = 1'b1;
        @(posedge clk); #1;

        // Two-word image.
        start_load();
        send(32'h0050_0093, 1'b0, 1'b1);
        send(32'h00A0_0113, 1'b1, 1'b1);
        complete_image(2);

        // Restart from RUN: core reset falls on the start edge; full 64 words.
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        addr_model = '0;
        sum_model  = '0;
        check("core_rst_restart", 64'(core_areset), 64'd0);
        check("busy_restart", 64'(busy), 64'd1);
        check("wc_restart", 64'(word_count), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            send(32'h1000_0000 + 32'(i * 3), (i == DEPTH - 1), 1'b1);
        end
        complete_image(DEPTH);

        // 64 words without in_last -> ERROR, no wrap to address 0.
        start_load();
        we_pulses = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send(32'hBEEF_0000 + 32'(i), 1'b0, 1'b1);
        end
        check("error_flag", 64'(error), 64'd1);
        check("core_rst_error", 64'(core_areset), 64'd0);
        check("in_ready_error", 64'(in_ready), 64'd0);
        check("wc_error", 64'(word_count), 64'(DEPTH));
        repeat (4) @(posedge clk);
        #1;
        check("error_hold", 64'(error), 64'd1);
        check("we_pulses_overflow", 64'(we_pulses), 64'(DEPTH));
        check("sb_overflow", 64'(exp_q.size()), 64'd0);

        // Leave ERROR via start; in_valid toggles with idle gaps.
        start_load();
        check("error_cleared", 64'(error), 64'd0);
        we_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            send(32'hA5A5_0000 | 32'(i), (i == 3), 1'b1);
            if (i != 3) begin
                @(posedge clk); #1;
            end
        end
        complete_image(4);
        check("we_pulses_toggle", 64'(we_pulses), 64'd4);

        // Reset mid-load after 3 words, then a 2-word image from address 0.
        start_load();
        for (int i = 0; i < 3; i++) begin
            send(32'hC0DE_0000 | 32'(i), 1'b0, 1'b1);
        end
        areset = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) areset = 1'b1;
        @(posedge clk); #1;
        start_load();
        send(32'h1111_2222, 1'b0, 1'b1);
        send(32'h3333_4444, 1'b1, 1'b1);
        complete_image(2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good checksum 1+2+3 = 6.
        start_load();
        send(32'd1, 1'b0, 1'b1);
        send(32'd2, 1'b0, 1'b1);
        send(32'd3, 1'b1, 1'b1);
        send(32'd6, 1'b0, 1'b0);
        check("cs_ok_done", 64'(done), 64'd1);
        check("cs_ok_core", 64'(core_areset), 64'd1);
        // Bad checksum 7.
        start_load();
        send(32'd1, 1'b0, 1'b1);
        send(32'd2, 1'b0, 1'b1);
        send(32'd3, 1'b1, 1'b1);
        send(32'd7, 1'b1, 1'b0);
        check("cs_bad_error", 64'(error), 64'd1);
        check("cs_bad_core", 64'(core_areset), 64'd0);
        check("cs_bad_done", 64'(done), 64'd0);
        @(negedge clk);
        check("cs_sb_drained", 64'(exp_q.size()), 64'd0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
